// File: rtl/phase_a_step.sv
// Montgomery reduction "A" phase: new_a = (a + q*m) / 2^56, conditionally
// reduced by m. Fully pipelined, one operation per clock, latency 3.
module phase_a_step (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3071:0] a,
  input  logic [3071:0] m,
  input  logic [3073:0] m_n,
  input  logic [55:0]   m_prime,
  input  logic          en,
  output logic [3071:0] new_a,
  output logic          en_out
);

  // Rank 0: operand capture at the sampling edge.
  logic [3071:0] a0, m0;
  logic [3073:0] mn0;
  logic [55:0]   mp0;
  logic          v0;

  // Rank 1: quotient digit alongside the operands it applies to.
  logic [3071:0] a1, m1;
  logic [3073:0] mn1;
  logic [55:0]   q1;
  logic          v1;

  // Rank 2: shifted sum, still one bit wider than the operand.
  logic [3072:0] t2;
  logic [3073:0] mn2;
  logic          v2;

  logic [55:0]   q_next;
  logic [3128:0] acc;
  logic [3072:0] t_next;
  logic [3073:0] d;
  logic [3071:0] res;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
    q_next = '0;
    acc    = '0;
    t_next = '0;
    d      = '0;
    res    = '0;

    // Self-determined 56-bit multiply gives q mod 2^56 directly.
    q_next = a0[55:0] * mp0;

    // Full 3129-bit sum so nothing is lost before the shift by one digit.
    acc    = {57'd0, a1} + ({3073'd0, q1} * {57'd0, m1});
    t_next = acc[3128:56];

    d   = {1'b0, t2} + mn2;
    res = d[3073] ? t2[3071:0] : d[3071:0];
  end

  // acc[55:0] is discarded by the division, d[3072] by the final truncation.
  logic unused_bits;
  assign unused_bits = ^{acc[55:0], d[3072]};

  // NOTE: data registers are reset too, so a reset leaves no stale operands or results visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0     <= '0;
      m0     <= '0;
      mn0    <= '0;
      mp0    <= '0;
      v0     <= 1'b0;
      a1     <= '0;
      m1     <= '0;
      mn1    <= '0;
      q1     <= '0;
      v1     <= 1'b0;
      t2     <= '0;
      mn2    <= '0;
      v2     <= 1'b0;
      new_a  <= '0;
      en_out <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every rank reads the previous value of the rank before it.
      v0 <= en;
      if (en) begin
        a0  <= a;
        m0  <= m;
        mn0 <= m_n;
        mp0 <= m_prime;
      end

      v1 <= v0;
      if (v0) begin
        a1  <= a0;
        m1  <= m0;
        mn1 <= mn0;
        q1  <= q_next;
      end

      v2 <= v1;
      if (v1) begin
        t2  <= t_next;
        mn2 <= mn1;
      end

      en_out <= v2;
      if (v2) new_a <= res;
    end
  end

endmodule

// File: tb/tb_phase_a_step.sv
// Scoreboard bench for phase_a_step: stimulus pushes expected results with
// their due cycle, a negedge monitor pops and compares.
module tb_phase_a_step;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3071:0] a, m;
  logic [3073:0] m_n;
  logic [55:0]   m_prime;
  logic          en;
  logic [3071:0] new_a;
  logic          en_out;

  phase_a_step dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .m       (m),
    .m_n     (m_n),
    .m_prime (m_prime),
    .en      (en),
    .new_a   (new_a),
    .en_out  (en_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [3071:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic ok,
                       input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%h want 0x%h (low 64 bits)", name, cyc, act, req);
    end
  endtask

  // Reference: Montgomery step straight from the arithmetic definition.
  function automatic logic [3071:0] model(input logic [3071:0] x,
                                          input logic [3071:0] mod,
                                          input logic [55:0]   mp);
    logic [111:0]  qp;
    logic [55:0]   q;
    logic [3129:0] s;
    logic [3129:0] t;
    qp = {56'd0, x[55:0]} * {56'd0, mp};
    q  = qp[55:0];
    s  = {58'd0, x} + ({3074'd0, q} * {58'd0, mod});
    t  = s >> 56;
    if (t >= {58'd0, mod}) t = t - {58'd0, mod};
    return t[3071:0];
  endfunction

  function automatic logic [3071:0] rand_w();
    logic [3071:0] r;
    for (int i = 0; i < 96; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [3073:0] neg(input logic [3071:0] x);
    return {2'b00, ~x} + 3074'd1 + {2'b11, 3072'd0};
  endfunction

  // Monitor: compares away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs", (new_a == '0) && (en_out == 1'b0),
            {63'd0, en_out} | new_a[63:0], 64'd0);
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      check("en_out_latency", en_out === 1'b1, {63'd0, en_out}, 64'd1);
      check("new_a", new_a === sb[0].val, new_a[63:0], sb[0].val[63:0]);
      void'(sb.pop_front());
    end else if (en_out !== 1'b0) begin
      check("unexpected_en_out", 1'b0, {63'd0, en_out}, 64'd0);
    end
  end

  // Drive one cycle; returns #1 after the sampling edge.
  task automatic drive(input logic e, input logic [3071:0] x, input logic [3071:0] mod,
                       input logic [55:0] mp);
    exp_t ex;
    a       = x;
    m       = mod;
    m_n     = neg(mod);
    m_prime = mp;
    en      = e;
    if (e && rst_n) begin
      ex.due = cyc + 4;
      ex.val = model(x, mod, mp);
      sb.push_back(ex);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, rand_w(), rand_w(), 56'($urandom));
  endtask

  logic [55:0] mp3;
  logic [3071:0] two56;

  initial begin
    rst_n   = 1'b0;
    en      = 1'b1;
    a       = '0;
    m       = '0;
    m_n     = '0;
    m_prime = '0;
    mp3     = 56'h55555555555555;
    two56   = 3072'd1 << 56;

    // Reset held with busy random inputs.
    for (int i = 0; i < 4; i++) drive(1'b1, rand_w(), rand_w(), 56'($urandom));
    rst_n = 1'b1;
    idle(4);

    // m = 1: t = 1 >= m, result 0.
    drive(1'b1, 3072'd5, 3072'd1, '1);
    idle(4);

    // m = 3 directed cases.
    drive(1'b1, two56, 3072'd3, mp3);
    idle(4);
    drive(1'b1, 3072'd6, 3072'd3, mp3);
    idle(4);

    // Back-to-back: expected 1, 2, 1, 2.
    drive(1'b1, two56,      3072'd3, mp3);
    drive(1'b1, two56 * 2,  3072'd3, mp3);
    drive(1'b1, two56 * 4,  3072'd3, mp3);
    drive(1'b1, two56 * 5,  3072'd3, mp3);
    idle(5);

    // Input stability: operands change right after sampling.
    drive(1'b1, rand_w(), rand_w() | 3072'd1, 56'($urandom));
    idle(5);

    // Reset mid-flight discards the operation.
    drive(1'b1, rand_w(), rand_w() | 3072'd1, 56'($urandom));
    idle(1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("async_reset_new_a", new_a == '0, new_a[63:0], 64'd0);
    check("async_reset_en_out", en_out == 1'b0, {63'd0, en_out}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, rand_w(), rand_w() | 3072'd1, 56'($urandom));
    idle(5);

    // Randomized traffic with random bubbles.
    for (int i = 0; i < 150; i++) begin
      logic [3071:0] mod;
      mod = rand_w();
      if ($urandom_range(0, 3) == 0) mod = mod >> $urandom_range(1, 3000);
      drive(1'($urandom_range(0, 3) != 0), rand_w(), mod, 56'($urandom));
    end

    // Drain with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) idle(1);
    if (sb.size() > 0) check("drain_timeout", 1'b0, 64'(sb.size()), 64'd0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
